// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared constants and types for the VGA scene blocks
package scene_pkg;

  typedef enum logic [1:0] {
    PHASE_DAWN  = 2'd0,
    PHASE_DAY   = 2'd1,
    PHASE_DUSK  = 2'd2,
    PHASE_NIGHT = 2'd3
  } phase_e;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SUN_RADIUS = 16;

  // Daytime phase implied by a sun x position; bands are 80 px in from each end.
  function automatic phase_e phase_for_x(input logic [10:0] x, input int x_min, input int x_max);
    if (x < 11'(x_min + 80))
      return PHASE_DAWN;
    else if (x < 11'(x_max - 80))
      return PHASE_DAY;
    else
      return PHASE_DUSK;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - registered rising-edge detector with configurable reset level
module sync_edge_det #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Previous-cycle copy of the input; resetting to the idle level avoids a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig_q <= RESET_LEVEL;
    else
      sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/scene_motion_ctrl.sv
// rtl/scene_motion_ctrl.sv - per-frame sun motion and day-cycle phase controller
module scene_motion_ctrl
  import scene_pkg::*;
#(
  parameter int X_MIN        = 40,
  parameter int X_MAX        = 600,
  parameter int Y_HIGH       = 60,
  parameter int Y_LOW        = 140,
  parameter int STEP         = 2,
  parameter int FRAME_DIV    = 2,
  parameter int NIGHT_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       enable,
  output logic [9:0] sun_x,
  output logic [9:0] sun_y,
  output logic       sun_visible,
  output logic [1:0] phase,
  output logic       frame_tick
);

  localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int NIGHT_W = (NIGHT_FRAMES > 1) ? $clog2(NIGHT_FRAMES) : 1;
  localparam int X_MID   = (X_MIN + X_MAX) / 2;

  logic               vsync_rise;
  logic               upd;
  phase_e             phase_q, phase_nxt, band_phase;
  logic [9:0]         x_nxt, y_nxt;
  logic               vis_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [NIGHT_W-1:0] night_cnt, night_nxt;
  logic [10:0]        nx;

  sync_edge_det #(
    .RESET_LEVEL (1'b1)
  ) u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vsync),
    .rise  (vsync_rise)
  );

  assign upd   = vsync_rise & enable;
  assign phase = phase_q;

  // Next-state for the day-cycle FSM and the sun datapath, evaluated once per accepted frame.
  always_comb begin
    phase_nxt  = phase_q;
    x_nxt      = sun_x;
    y_nxt      = sun_y;
    vis_nxt    = sun_visible;
    div_nxt    = div_cnt;
    night_nxt  = night_cnt;
    nx         = {1'b0, sun_x} + 11'(STEP);
    band_phase = phase_for_x(nx, X_MIN, X_MAX);
    if (upd) begin
      if (phase_q == PHASE_NIGHT) begin
        div_nxt = '0;
        if (night_cnt == NIGHT_W'(NIGHT_FRAMES - 1)) begin
          phase_nxt = PHASE_DAWN;
          x_nxt     = 10'(X_MIN);
          y_nxt     = 10'(Y_LOW);
          vis_nxt   = 1'b1;
          night_nxt = '0;
        end else begin
          night_nxt = night_cnt + 1'b1;
        end
      end else if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
        div_nxt = '0;
        if (nx >= 11'(X_MAX)) begin
          phase_nxt = PHASE_NIGHT;
          x_nxt     = 10'(X_MAX);
          vis_nxt   = 1'b0;
          night_nxt = '0;
        end else begin
          x_nxt = nx[9:0];
          if (nx < 11'(X_MID))
            y_nxt = (sun_y > 10'(Y_HIGH)) ? sun_y - 10'd1 : 10'(Y_HIGH);
          else
            y_nxt = (sun_y < 10'(Y_LOW)) ? sun_y + 10'd1 : 10'(Y_LOW);
          if (band_phase > phase_q)
            phase_nxt = band_phase;
        end
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end
  end

  // State and output registers; async reset returns the sun to sunrise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PHASE_DAWN;
      sun_x       <= 10'(X_MIN);
      sun_y       <= 10'(Y_LOW);
      sun_visible <= 1'b1;
      div_cnt     <= '0;
      night_cnt   <= '0;
      frame_tick  <= 1'b0;
    end else begin
      phase_q     <= phase_nxt;
      sun_x       <= x_nxt;
      sun_y       <= y_nxt;
      sun_visible <= vis_nxt;
      div_cnt     <= div_nxt;
      night_cnt   <= night_nxt;
      frame_tick  <= upd;
    end
  end

endmodule

// File: tb/tb_scene_motion_ctrl.sv
// tb/tb_scene_motion_ctrl.sv - self-checking bench with behavioural model for scene_motion_ctrl
module tb_scene_motion_ctrl;

  localparam int XMIN = 40, XMAX = 600, YH = 60, YL = 140, STP = 2, FD = 2, NF = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       enable = 1'b1;
  logic [9:0] sun_x, sun_y;
  logic       sun_visible;
  logic [1:0] phase;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;

  // behavioural model state
  int m_x, m_y, m_phase, m_vis, m_div, m_night, m_vsq, m_tick;

  scene_motion_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .enable      (enable),
    .sun_x       (sun_x),
    .sun_y       (sun_y),
    .sun_visible (sun_visible),
    .phase       (phase),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one frame of the day cycle, applied whenever a vsync rising edge is accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x = XMIN; m_y = YL; m_phase = 0; m_vis = 1; m_div = 0; m_night = 0; m_vsq = 1; m_tick = 0;
    end else begin
      m_tick = (vsync && !m_vsq && enable) ? 1 : 0;
      if (m_tick == 1) begin
        if (m_phase == 3) begin
          m_night++;
          if (m_night == NF) begin
            m_x = XMIN; m_y = YL; m_phase = 0; m_vis = 1; m_night = 0; m_div = 0;
          end
        end else begin
          m_div++;
          if (m_div == FD) begin
            int nx;
            int band;
            m_div = 0;
            nx = m_x + STP;
            if (nx >= XMAX) begin
              m_x = XMAX; m_phase = 3; m_vis = 0; m_night = 0;
            end else begin
              m_x = nx;
              if (nx < (XMIN + XMAX) / 2) m_y = (m_y - 1 < YH) ? YH : m_y - 1;
              else                        m_y = (m_y + 1 > YL) ? YL : m_y + 1;
              band = (nx < XMIN + 80) ? 0 : (nx < XMAX - 80) ? 1 : 2;
              if (band > m_phase) m_phase = band;
            end
          end
        end
      end
      m_vsq = vsync ? 1 : 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("sun_x", int'(sun_x), m_x);
    chk("sun_y", int'(sun_y), m_y);
    chk("phase", int'(phase), m_phase);
    chk("sun_visible", int'(sun_visible), m_vis);
    chk("frame_tick", int'(frame_tick), m_tick);
    if (frame_tick) tick_cnt++;
  end

  task automatic vedge();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (2 * n) vedge();
  endtask

  task automatic chk_out(input string tag, input int x, input int y, input int ph, input int vis);
    chk({tag, ".x"}, int'(sun_x), x);
    chk({tag, ".y"}, int'(sun_y), y);
    chk({tag, ".phase"}, int'(phase), ph);
    chk({tag, ".vis"}, int'(sun_visible), vis);
  endtask

  initial begin
    int t0;
    int guard;
    // 1: reset with vsync held high, then no tick while it stays high
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_out("reset", 40, 140, 0, 1);
    chk("reset.ticks", tick_cnt, 0);

    // 2: two edges -> two single-cycle ticks, one step
    vedge();
    chk("e1.tick", int'(frame_tick), 1);
    chk("e1.x", int'(sun_x), 40);
    @(negedge clk);
    chk("e1.tick_width", int'(frame_tick), 0);
    vedge();
    chk("e2.tick", int'(frame_tick), 1);
    chk_out("e2", 42, 139, 0, 1);
    chk("e2.ticks", tick_cnt, 2);

    // 3: trajectory landmarks
    steps(39);  chk_out("x120", 120, 100, 1, 1);
    steps(40);  chk_out("x200", 200, 60, 1, 1);
    steps(59);  chk_out("x318", 318, 60, 1, 1);
    steps(1);   chk_out("x320", 320, 61, 1, 1);
    steps(100); chk_out("x520", 520, 140, 2, 1);
    steps(39);  chk_out("x598", 598, 140, 2, 1);

    // 4: sunset into night, then back to dawn after NIGHT_FRAMES edges
    steps(1);   chk_out("sunset", 600, 140, 3, 0);
    repeat (119) vedge();
    chk_out("night119", 600, 140, 3, 0);
    vedge();
    chk_out("dawn", 40, 140, 0, 1);

    // 5: enable low freezes state, divider position kept
    vedge();
    chk_out("pre_freeze", 40, 140, 0, 1);
    @(negedge clk) enable = 1'b0;
    t0 = tick_cnt;
    repeat (10) vedge();
    chk_out("frozen", 40, 140, 0, 1);
    chk("frozen.ticks", tick_cnt - t0, 0);
    @(negedge clk) enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_rise.ticks", tick_cnt - t0, 0);
    vedge();
    chk_out("thaw", 42, 139, 0, 1);

    // random vsync timing and enable, checked each cycle by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      vsync = 1'b0;
      enable = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      vsync = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk) enable = 1'b1;

    // 6: async reset mid-night
    guard = 0;
    while (m_phase != 3 && guard < 2000) begin
      vedge();
      guard++;
    end
    chk("reach_night", m_phase, 3);
    repeat (5) vedge();
    chk("mid_night.phase", int'(phase), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 40, 140, 0, 1);
    chk("async_rst.tick", int'(frame_tick), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("post_rst", 40, 140, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
